// File: rtl/mig_cmd_arbiter.sv
// Urgent-first round-robin arbiter that shares the single MIG command port; accept -> mig_cmd_en is 1 cycle.
// Backpressure: nothing is accepted while mig_cmd_full is high; at most one command per 2+GAP_CYCLES cycles.
module mig_cmd_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 30,
    parameter int GAP_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_urgent,
    input  logic [3*NUM_REQ-1:0]      req_instr,
    input  logic [6*NUM_REQ-1:0]      req_bl,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      mig_cmd_en,
    output logic [2:0]                mig_cmd_instr,
    output logic [5:0]                mig_cmd_bl,
    output logic [ADDR_W-1:0]         mig_cmd_byte_addr,
    input  logic                      mig_cmd_full,
    output logic [1:0]                grant_id,
    output logic                      busy,
    output logic                      error
);
    typedef enum logic [1:0] {ARB = 2'd0, ISSUE = 2'd1, GAP = 2'd2} state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t            state_q, state_d;
    logic [1:0]        last_grant_q, last_grant_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [2:0]        instr_q, instr_d;
    logic [5:0]        bl_q, bl_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              error_q, error_d;

    logic [NUM_REQ-1:0] cand;
    logic [2:0]         idx;
    logic [1:0]         winner;
    logic               win_found;
    logic               accept;
    logic [2:0]         win_instr;
    logic [5:0]         win_bl;
    logic [ADDR_W-1:0]  win_addr;

    // Urgent requesters mask everyone else; search starts just after the last winner.
    always_comb begin
        cand      = (|(req_valid & req_urgent)) ? (req_valid & req_urgent) : req_valid;
        winner    = '0;
        win_found = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, last_grant_q} + 3'(k);
            if (idx >= 3'(NUM_REQ)) begin
                idx = idx - 3'(NUM_REQ);
            end
            if (!win_found && cand[idx[1:0]]) begin
                win_found = 1'b1;
                winner    = idx[1:0];
            end
        end
    end

    assign win_instr = req_instr[3*int'(winner) +: 3];
    assign win_bl    = req_bl[6*int'(winner) +: 6];
    assign win_addr  = req_addr[ADDR_W*int'(winner) +: ADDR_W];
    assign accept    = rst_n && (state_q == ARB) && !mig_cmd_full && win_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        gap_cnt_d    = gap_cnt_q;
        instr_d      = instr_q;
        bl_d         = bl_q;
        addr_d       = addr_q;
        error_d      = error_q;
        case (state_q)
            ARB: begin
                if (accept) begin
                    last_grant_d = winner;
                    grant_id_d   = winner;
                    // Illegal opcodes are consumed so the requester is released, but never pushed.
                    if (win_instr[2]) begin
                        error_d = 1'b1;
                    end else begin
                        instr_d = win_instr;
                        bl_d    = win_bl;
                        addr_d  = win_addr;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (GAP_CYCLES > 0) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = ARB;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ARB;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ARB;
            last_grant_q <= 2'(NUM_REQ - 1);
            grant_id_q   <= '0;
            gap_cnt_q    <= '0;
            instr_q      <= '0;
            bl_q         <= '0;
            addr_q       <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            gap_cnt_q    <= gap_cnt_d;
            instr_q      <= instr_d;
            bl_q         <= bl_d;
            addr_q       <= addr_d;
            error_q      <= error_d;
        end
    end

    // Reset held during ISSUE drops the pending push.
    assign mig_cmd_en        = (state_q == ISSUE) && rst_n;
    assign mig_cmd_instr     = instr_q;
    assign mig_cmd_bl        = bl_q;
    assign mig_cmd_byte_addr = addr_q;
    assign grant_id          = grant_id_q;
    assign busy              = (state_q != ARB);
    assign error             = error_q;
endmodule
